// File: rtl/cla_acc_ctrl_if.sv
// cla_acc_ctrl_if: term stream, cla adder bus and result stream of the MACC accumulation controller.
interface cla_acc_ctrl_if #(parameter int N = 16, parameter int LEN_W = 8);
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic [N-1:0]     cla_a;
    logic [N-1:0]     cla_b;
    logic             cla_cin;
    logic [N-1:0]     cla_sum;
    logic             cla_cout;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic             out_ovf;
    logic             busy;
    modport master (
        input  start, cfg_len, in_valid, in_data, cla_sum, cla_cout, out_ready,
        output in_ready, cla_a, cla_b, cla_cin, out_valid, out_data, out_ovf, busy
    );
    modport slave (
        output start, cfg_len, in_valid, in_data, cla_sum, cla_cout, out_ready,
        input  in_ready, cla_a, cla_b, cla_cin, out_valid, out_data, out_ovf, busy
    );
endinterface

// File: rtl/cla_acc_ctrl.sv
// cla_acc_ctrl: accumulates signed terms through a pipelined cla adder and emits one result per cfg_len terms.
// Define CLA_ACC_SAT_EN to clamp the running sum on signed overflow instead of wrapping.
module cla_acc_ctrl #(
    parameter int N       = 16,
    parameter int CLA_LAT = 1,
    parameter int LEN_W   = 8
) (
    input logic           clk,
    input logic           rst,
    cla_acc_ctrl_if.master bus
);
    localparam int WW = $clog2(CLA_LAT + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    logic [1:0]       state;
    logic [N-1:0]     acc;
    logic [N-1:0]     nxt_acc;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len;
    logic [WW-1:0]    wcnt;
    logic             ovf;
    logic             capture;
    logic             unused_cout;
    assign unused_cout  = bus.cla_cout;
    assign bus.cla_cin  = 1'b0;
    assign bus.in_ready = state == ISSUE;
    assign bus.out_valid = state == DONE;
    assign bus.busy     = state != IDLE;
    assign capture      = state == WAIT && wcnt == WW'(CLA_LAT);
    assign ovf = (bus.cla_a[N-1] == bus.cla_b[N-1]) && (bus.cla_sum[N-1] != bus.cla_a[N-1]);
    always_comb begin
`ifdef CLA_ACC_SAT_EN
        nxt_acc = !ovf ? bus.cla_sum :
                  bus.cla_a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`else
        nxt_acc = bus.cla_sum;
`endif
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            len          <= '0;
            wcnt         <= '0;
            bus.cla_a    <= '0;
            bus.cla_b    <= '0;
            bus.out_data <= '0;
            bus.out_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state       <= ISSUE;
                    acc         <= '0;
                    cnt         <= '0;
                    bus.out_ovf <= 1'b0;
                    len         <= bus.cfg_len == '0 ? LEN_W'(1) : bus.cfg_len;
                end
                ISSUE: if (bus.in_valid) begin
                    bus.cla_a <= acc;
                    bus.cla_b <= bus.in_data;
                    wcnt      <= '0;
                    state     <= WAIT;
                end
                WAIT: if (capture) begin
                    acc <= nxt_acc;
                    cnt <= cnt + 1'b1;
                    if (ovf) bus.out_ovf <= 1'b1;
                    if (cnt == len - 1'b1) bus.out_data <= nxt_acc;
                    state <= cnt == len - 1'b1 ? DONE : ISSUE;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
                default: if (bus.out_ready) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cla_acc_ctrl.sv
// tb_cla_acc_ctrl: directed vectors for cla_acc_ctrl with a CLA_LAT-stage cla adder model.
module tb_cla_acc_ctrl;
    localparam int N = 16;
    localparam int CLA_LAT = 1;
    localparam int LEN_W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    logic [N-1:0] exp_a = '0;
    logic [N-1:0] exp_b = '0;
    logic [N-1:0] macc = '0;
    logic [N:0] pipe [CLA_LAT];
    logic [N-1:0] sat_hi;
    logic [N-1:0] sat_lo;

    cla_acc_ctrl_if #(.N(N), .LEN_W(LEN_W)) bus ();
    cla_acc_ctrl #(.N(N), .CLA_LAT(CLA_LAT), .LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_ff @(posedge clk) begin
        pipe[0] <= {1'b0, bus.cla_a} + {1'b0, bus.cla_b} + (N+1)'(bus.cla_cin);
        for (int i = 1; i < CLA_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.cla_sum  = pipe[CLA_LAT-1][N-1:0];
    assign bus.cla_cout = pipe[CLA_LAT-1][N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [LEN_W-1:0] l);
        bus.start = 1'b1;
        bus.cfg_len = l;
        t0 = cyc;
        macc = '0;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send(input string tag, input logic [N-1:0] d, input int gap);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk({tag, "_ready_timeout"}, 0, 1);
        for (int g = 0; g < gap; g++) begin
            chk({tag, "_gap_ready"}, 32'(bus.in_ready), 1);
            chk({tag, "_gap_a"}, 32'(bus.cla_a), 32'(exp_a));
            chk({tag, "_gap_b"}, 32'(bus.cla_b), 32'(exp_b));
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data = d;
        @(negedge clk);
        bus.in_valid = 1'b0;
        exp_a = macc;
        exp_b = d;
        macc = macc + d;
        chk({tag, "_cla_b"}, 32'(bus.cla_b), 32'(d));
    endtask

    task automatic wait_out(input string tag);
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk({tag, "_valid_timeout"}, 0, 1);
    endtask

    task automatic finish_run(input string tag, input logic [N-1:0] d, input logic o);
        wait_out(tag);
        chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
        chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(o));
        chk({tag, "_busy"}, 32'(bus.busy), 1);
        @(negedge clk);
        chk({tag, "_valid_clr"}, 32'(bus.out_valid), 0);
    endtask

    initial begin
`ifdef CLA_ACC_SAT_EN
        sat_hi = 16'h7FFF;
        sat_lo = 16'h8000;
`else
        sat_hi = 16'h8000;
        sat_lo = 16'h7FFF;
`endif
        bus.start = 1'b0;
        bus.cfg_len = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_cla_a", 32'(bus.cla_a), 0);
        chk("rst_cla_b", 32'(bus.cla_b), 0);
        chk("rst_cla_cin", 32'(bus.cla_cin), 0);
        rst = 1'b0;
        @(negedge clk);

        do_start(8'd3);
        chk("a_busy", 32'(bus.busy), 1);
        send("a1", 16'd10, 0);
        send("a2", 16'd20, 0);
        send("a3", 16'd30, 0);
        wait_out("a");
        chk("a_latency", 32'(cyc - t0), 32'(3 * (CLA_LAT + 2) + 1));
        finish_run("a", 16'd60, 1'b0);

        do_start(8'd2);
        send("b1", 16'hFFF1, 0);
        send("b2", 16'd5, 0);
        finish_run("b", 16'hFFF6, 1'b0);

        do_start(8'd2);
        send("c1", 16'h7FFF, 0);
        send("c2", 16'd1, 0);
        finish_run("c", sat_hi, 1'b1);

        do_start(8'd2);
        send("d1", 16'h8000, 0);
        send("d2", 16'hFFFF, 0);
        finish_run("d", sat_lo, 1'b1);

        do_start(8'd3);
        send("e1", 16'd10, 4);
        send("e2", 16'd20, 4);
        send("e3", 16'd30, 4);
        finish_run("e", 16'd60, 1'b0);

        bus.out_ready = 1'b0;
        do_start(8'd2);
        send("f1", 16'd3, 0);
        send("f2", 16'd4, 0);
        wait_out("f");
        for (int k = 0; k < 5; k++) begin
            chk("f_hold_valid", 32'(bus.out_valid), 1);
            chk("f_hold_data", 32'(bus.out_data), 7);
            chk("f_hold_ovf", 32'(bus.out_ovf), 0);
            chk("f_hold_ready", 32'(bus.in_ready), 0);
            bus.start = (k == 2);
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("f_xfer_valid", 32'(bus.out_valid), 0);
        chk("f_xfer_busy", 32'(bus.busy), 0);
        @(negedge clk);
        chk("f_idle_busy", 32'(bus.busy), 0);

        do_start(8'd2);
        send("g1", 16'd100, 0);
        rst = 1'b1;
        #1;
        chk("g_rst_cla_a", 32'(bus.cla_a), 0);
        chk("g_rst_cla_b", 32'(bus.cla_b), 0);
        chk("g_rst_busy", 32'(bus.busy), 0);
        chk("g_rst_in_ready", 32'(bus.in_ready), 0);
        chk("g_rst_out_valid", 32'(bus.out_valid), 0);
        chk("g_rst_out_data", 32'(bus.out_data), 0);
        chk("g_rst_out_ovf", 32'(bus.out_ovf), 0);
        exp_a = '0;
        exp_b = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("g_idle_busy", 32'(bus.busy), 0);
        chk("g_idle_data", 32'(bus.out_data), 0);
        do_start(8'd0);
        send("h1", 16'd7, 0);
        finish_run("h", 16'd7, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
